// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port index, port count.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef logic port_idx_t;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner picker for two requesters; round-robin on ties by default.
// MEM_PORT_ARBITER_FIXED_PRIO_EN selects strict port-0 priority instead.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            last,
    output logic [NUM_PORTS-1:0] win
);

`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
    port_idx_t unused_last;
    assign unused_last = last;

    always_comb begin
        win = '0;
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
    end
`else
    // On a tie the port that was not served last goes next.
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the CPU (port 0) and a loader (port 1).
// Define MEM_PORT_ARBITER_FIXED_PRIO_EN to give port 0 strict priority on ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] wr,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    wdata0,
    input  logic [DATA_W-1:0]    wdata1,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [NUM_PORTS-1:0] done,
    output logic [DATA_W-1:0]    rdata,
    output logic                 busy,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_wr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);

    localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

    arb_state_t           state_q, state_d;
    port_idx_t            idx_q, idx_d;
    port_idx_t            last_w;
    logic                 wr_q, wr_d;
    logic [2:0]           lat_q, lat_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] win;

    arb_rr_pick u_pick (
        .req  (req),
        .last (last_w),
        .win  (win)
    );

`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
    assign last_w = 1'b1;
`else
    port_idx_t last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (state_q == DONE) begin
            last_q <= idx_q;
        end
    end

    assign last_w = last_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 1'b0;
            wr_q        <= 1'b0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            lat_q       <= lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        lat_d       = lat_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_d    = 1'b0;
        rdata_d     = rdata_q;
        gnt         = '0;
        done        = '0;
        busy        = 1'b0;
        rdata       = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt         = win;
                    busy        = 1'b1;
                    idx_d       = win[1];
                    wr_d        = wr[win[1]];
                    mem_addr_d  = win[1] ? addr1 : addr0;
                    mem_wdata_d = win[1] ? wdata1 : wdata0;
                    mem_wr_d    = wr[win[1]];
                    lat_d       = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                busy  = 1'b1;
                lat_d = lat_q + 3'd1;
                if (lat_q == LAT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = idx_q ? 2'b10 : 2'b01;
                state_d = IDLE;
                // Read data is forwarded in the done cycle and held afterwards.
                if (!wr_q) begin
                    rdata   = mem_rdata;
                    rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            gnt   = '0;
            done  = '0;
            busy  = 1'b0;
            rdata = rdata_q;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q & ~reset;

endmodule
